// File: rtl/ff_layer_sequencer.sv
// Layer sequencer for a feed-forward node array: fires each layer in turn, collects
// every node's valid pulse, and reports completion, timeout error and total cycles.
module ff_layer_sequencer #(
    parameter int NUM_LAYERS      = 3,
    parameter int NODES_PER_LAYER = 32,
    parameter int LAYER_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES  = 1023,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_start,
    input  logic                                  i_abort,
    input  logic [NUM_LAYERS*NODES_PER_LAYER-1:0] i_node_valid,
    output logic [NUM_LAYERS-1:0]                 o_layer_start,
    output logic [LAYER_WIDTH-1:0]                o_cur_layer,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_error,
    output logic [CNT_WIDTH-1:0]                  o_cycle_count
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0]       TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LAYER_WIDTH-1:0] LAST_LAYER = LAYER_WIDTH'(NUM_LAYERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                       state_q, state_d;
    logic [LAYER_WIDTH-1:0]       layer_q, layer_d;
    logic [NODES_PER_LAYER-1:0]   sticky_q, sticky_d;
    logic [TMR_W-1:0]             timer_q, timer_d;
    logic                         err_q, err_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic [NUM_LAYERS-1:0]        lstart_q, lstart_d;
    logic                         done_q, done_d;
    logic [NODES_PER_LAYER-1:0]   slice;
    logic                         layer_complete;

    always_comb begin
        slice = '0;
        for (int unsigned l = 0; l < NUM_LAYERS; l++) begin
            if (layer_q == LAYER_WIDTH'(l)) begin
                slice = i_node_valid[l*NODES_PER_LAYER +: NODES_PER_LAYER];
            end
        end
    end

    // Bits arriving this cycle count toward completion immediately.
    assign layer_complete = &(sticky_q | slice);

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        sticky_d = sticky_q;
        timer_d  = timer_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        lstart_d = '0;
        done_d   = 1'b0;

        if (state_q != S_IDLE && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    state_d = S_FIRE;
                    layer_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_FIRE: begin
                sticky_d = '0;
                timer_d  = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                sticky_d = sticky_q | slice;
                timer_d  = timer_q + 1'b1;
                if (layer_complete) begin
                    if (layer_q != LAST_LAYER) begin
                        layer_d = layer_q + 1'b1;
                        state_d = S_FIRE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort keeps the reported layer and error flag as they were.
        if (i_abort) begin
            state_d = S_IDLE;
            layer_d = layer_q;
            err_d   = err_q;
        end

        for (int unsigned l = 0; l < NUM_LAYERS; l++) begin
            lstart_d[l] = (state_d == S_FIRE) && (layer_d == LAYER_WIDTH'(l));
        end
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            layer_q  <= '0;
            sticky_q <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            lstart_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            sticky_q <= sticky_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            lstart_q <= lstart_d;
            done_q   <= done_d;
        end
    end

    assign o_layer_start = lstart_q;
    assign o_cur_layer   = layer_q;
    assign o_busy        = (state_q == S_FIRE) || (state_q == S_WAIT);
    assign o_done        = done_q;
    assign o_error       = err_q;
    assign o_cycle_count = cnt_q;

endmodule
